// File: rtl/transmissor_medidas_dht11.sv
// Formats latched DHT11 temperature/humidity as "TT.T;UU.U\r\n" and sends it over a UART TX line.
// Define TX_PARITY_EN to insert an even-parity bit per character (8E1); default build is 8N1.
module transmissor_medidas_dht11 #(
    parameter int BAUD_DIV = 5208
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        transmitir,
    input  logic [15:0] temperatura,
    input  logic [15:0] umidade,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        pronto
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [3:0]    IDX_LAST  = 4'd10;

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
        INICIO,
        DADOS,
`ifdef TX_PARITY_EN
        PARIDADE,
`endif
        PARADA,
        FIM
    } estado_t;

    estado_t       estado, estado_next;
    logic [BW-1:0] baud_cnt, baud_next;
    logic [2:0]    bit_cnt, bit_next;
    logic [3:0]    indice, indice_next;
    logic          serial_next;
    logic          baud_fim;
    logic          conv_done;

    logic [6:0]    t_resto, u_resto;
    logic [3:0]    t_dezena, u_dezena;
    logic [3:0]    t_dec, u_dec;
    logic [7:0]    caractere;

    function automatic logic [6:0] satura_int(input logic [7:0] v);
        return (v >= 8'd99) ? 7'd99 : v[6:0];
    endfunction

    function automatic logic [3:0] satura_dec(input logic [7:0] v);
        return (v > 8'd9) ? 4'd9 : v[3:0];
    endfunction

    assign baud_fim  = (baud_cnt == BAUD_LAST);
    assign conv_done = (t_resto < 7'd10) && (u_resto < 7'd10);

    // Subtract-10 loop: remainder ends as the units digit, at most 9 steps per word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            t_resto  <= '0;
            u_resto  <= '0;
            t_dezena <= '0;
            u_dezena <= '0;
            t_dec    <= '0;
            u_dec    <= '0;
        end else if (estado == OCIOSO && transmitir) begin
            t_resto  <= satura_int(temperatura[15:8]);
            u_resto  <= satura_int(umidade[15:8]);
            t_dezena <= '0;
            u_dezena <= '0;
            t_dec    <= satura_dec(temperatura[7:0]);
            u_dec    <= satura_dec(umidade[7:0]);
        end else if (estado == CARREGA) begin
            if (t_resto >= 7'd10) begin
                t_resto  <= t_resto - 7'd10;
                t_dezena <= t_dezena + 4'd1;
            end
            if (u_resto >= 7'd10) begin
                u_resto  <= u_resto - 7'd10;
                u_dezena <= u_dezena + 4'd1;
            end
        end
    end

    always_comb begin
        case (indice)
            4'd0:    caractere = {4'h3, t_dezena};
            4'd1:    caractere = {4'h3, t_resto[3:0]};
            4'd2:    caractere = 8'h2E;
            4'd3:    caractere = {4'h3, t_dec};
            4'd4:    caractere = 8'h3B;
            4'd5:    caractere = {4'h3, u_dezena};
            4'd6:    caractere = {4'h3, u_resto[3:0]};
            4'd7:    caractere = 8'h2E;
            4'd8:    caractere = {4'h3, u_dec};
            4'd9:    caractere = 8'h0D;
            default: caractere = 8'h0A;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= OCIOSO;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            indice       <= '0;
            saida_serial <= 1'b1;
        end else begin
            estado       <= estado_next;
            baud_cnt     <= baud_next;
            bit_cnt      <= bit_next;
            indice       <= indice_next;
            saida_serial <= serial_next;
        end
    end

    always_comb begin
        estado_next = estado;
        baud_next   = baud_cnt;
        bit_next    = bit_cnt;
        indice_next = indice;
        case (estado)
            OCIOSO: begin
                if (transmitir) estado_next = CARREGA;
            end
            CARREGA: begin
                baud_next   = '0;
                bit_next    = '0;
                indice_next = '0;
                if (conv_done) estado_next = INICIO;
            end
            INICIO: begin
                if (baud_fim) begin
                    baud_next   = '0;
                    estado_next = DADOS;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            DADOS: begin
                if (baud_fim) begin
                    baud_next = '0;
                    bit_next  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef TX_PARITY_EN
                        estado_next = PARIDADE;
`else
                        estado_next = PARADA;
`endif
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`ifdef TX_PARITY_EN
            PARIDADE: begin
                if (baud_fim) begin
                    baud_next   = '0;
                    estado_next = PARADA;
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
`endif
            PARADA: begin
                if (baud_fim) begin
                    baud_next = '0;
                    if (indice == IDX_LAST) begin
                        estado_next = FIM;
                    end else begin
                        indice_next = indice + 4'd1;
                        estado_next = INICIO;
                    end
                end else begin
                    baud_next = baud_cnt + 1'b1;
                end
            end
            FIM:     estado_next = OCIOSO;
            default: estado_next = OCIOSO;
        endcase
    end

    // Line level is decoded from the next state so the registered output lines up with it.
    always_comb begin
        serial_next = 1'b1;
        case (estado_next)
            INICIO:   serial_next = 1'b0;
            DADOS:    serial_next = caractere[bit_next];
`ifdef TX_PARITY_EN
            PARIDADE: serial_next = ^caractere;
`endif
            default:  serial_next = 1'b1;
        endcase
        ocupado = (estado != OCIOSO) && (estado != FIM);
        pronto  = (estado == FIM);
    end

endmodule

// File: tb/tb_transmissor_medidas_dht11.sv
// Directed bench for transmissor_medidas_dht11 with BAUD_DIV=4; decodes the serial line bit by bit.
// Follows TX_PARITY_EN the same way the design does.
module tb_transmissor_medidas_dht11;

    localparam int BD = 4;
`ifdef TX_PARITY_EN
    localparam int CHAR_T = 11;
`else
    localparam int CHAR_T = 10;
`endif
    localparam int FRAME_T = 11 * CHAR_T * BD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        transmitir = 1'b0;
    logic [15:0] temperatura = '0;
    logic [15:0] umidade = '0;
    logic        saida_serial;
    logic        ocupado;
    logic        pronto;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_pronto = 0;

    transmissor_medidas_dht11 #(.BAUD_DIV(BD)) dut (
        .clock        (clock),
        .reset        (reset),
        .transmitir   (transmitir),
        .temperatura  (temperatura),
        .umidade      (umidade),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (pronto === 1'b1) n_pronto = n_pronto + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
        $fatal(1);
    end

    task automatic pulse(input logic [15:0] t, input logic [15:0] u, output int cap);
        @(negedge clock);
        temperatura = t;
        umidade     = u;
        transmitir  = 1'b1;
        @(negedge clock);
        transmitir = 1'b0;
        cap = cyc;
        n_cmp++;
        if (ocupado !== 1'b1) begin
            n_err++;
            $display("FAIL capture_ocupado: got %b expected 1", ocupado);
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int w = 0; w < 400; w++) begin
            @(negedge clock);
            if (saida_serial === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic recv_char(output logic [7:0] b, output int start, output bit ok);
        b = '0;
        start = cyc;
        wait_start(ok);
        if (!ok) return;
        start = cyc;
        repeat (BD / 2) @(negedge clock);
        if (saida_serial !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge clock);
            b[i] = saida_serial;
        end
`ifdef TX_PARITY_EN
        repeat (BD) @(negedge clock);
        if (saida_serial !== ^b) ok = 1'b0;
`endif
        repeat (BD) @(negedge clock);
        if (saida_serial !== 1'b1) ok = 1'b0;
    endtask

    task automatic recv_frame(input logic [87:0] exp, input string nm, output int first);
        logic [7:0] b;
        int         st;
        bit         ok;
        first = cyc;
        for (int i = 0; i < 11; i++) begin
            recv_char(b, st, ok);
            if (i == 0) first = st;
            n_cmp++;
            if (!ok || b !== exp[8*(10-i) +: 8]) begin
                n_err++;
                $display("FAIL %s char%0d: got 0x%02h framing_ok=%0d expected 0x%02h", nm, i, b, ok, exp[8*(10-i) +: 8]);
            end
            if (i > 0) begin
                n_cmp++;
                if (st != first + i * CHAR_T * BD) begin
                    n_err++;
                    $display("FAIL %s char%0d_start: got cycle %0d expected %0d", nm, i, st, first + i * CHAR_T * BD);
                end
            end
        end
    endtask

    task automatic wait_pronto(input string nm, input int first);
        bit ok = 1'b0;
        int pc = 0;
        for (int w = 0; w < 100; w++) begin
            if (pronto === 1'b1) begin
                ok = 1'b1;
                pc = cyc;
                break;
            end
            @(negedge clock);
        end
        n_cmp++;
        if (!ok || pc - first != FRAME_T) begin
            n_err++;
            $display("FAIL %s pronto_time: got %0d cycles (seen=%0d) expected %0d", nm, pc - first, ok, FRAME_T);
        end
        n_cmp++;
        if (ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL %s ocupado_at_pronto: got %b expected 0", nm, ocupado);
        end
    endtask

    task automatic check_latency(input string nm, input int cap, input int first);
        n_cmp++;
        if (first - cap > 17 || first - cap < 1) begin
            n_err++;
            $display("FAIL %s start_latency: got %0d cycles expected 1..17", nm, first - cap);
        end
    endtask

    task automatic check_pronto_count(input string nm, input int expected);
        repeat (2) @(negedge clock);
        n_cmp++;
        if (n_pronto != expected) begin
            n_err++;
            $display("FAIL %s pronto_count: got %0d expected %0d", nm, n_pronto, expected);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (saida_serial !== 1'b1) begin n_err++; $display("FAIL reset_serial: got %b expected 1", saida_serial); end
        n_cmp++;
        if (ocupado !== 1'b0) begin n_err++; $display("FAIL reset_ocupado: got %b expected 0", ocupado); end
        n_cmp++;
        if (pronto !== 1'b0) begin n_err++; $display("FAIL reset_pronto: got %b expected 0", pronto); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (saida_serial !== 1'b1 || ocupado !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got serial=%b ocupado=%b expected 1/0", saida_serial, ocupado);
        end
    endtask

    task automatic test_basic_frame();
        int cap, first, n0;
        n0 = n_pronto;
        pulse(16'h1905, 16'h3C00, cap);
        temperatura = 16'h9999;
        umidade     = 16'h0101;
        recv_frame({8'h32, 8'h35, 8'h2E, 8'h35, 8'h3B, 8'h36, 8'h30, 8'h2E, 8'h30, 8'h0D, 8'h0A}, "basic", first);
        check_latency("basic", cap, first);
        wait_pronto("basic", first);
        check_pronto_count("basic", n0 + 1);
    endtask

    task automatic test_saturation();
        int cap, first, n0;
        n0 = n_pronto;
        pulse(16'h070C, 16'hFFFF, cap);
        recv_frame({8'h30, 8'h37, 8'h2E, 8'h39, 8'h3B, 8'h39, 8'h39, 8'h2E, 8'h39, 8'h0D, 8'h0A}, "saturation", first);
        check_latency("saturation", cap, first);
        wait_pronto("saturation", first);
        check_pronto_count("saturation", n0 + 1);
    endtask

    task automatic test_busy_rejection();
        int cap, first, n0;
        bit quiet;
        n0 = n_pronto;
        pulse(16'h1414, 16'h3201, cap);
        fork
            begin
                repeat (100) @(negedge clock);
                temperatura = 16'h0101;
                umidade     = 16'h0202;
                transmitir  = 1'b1;
                @(negedge clock);
                transmitir = 1'b0;
            end
        join_none
        recv_frame({8'h32, 8'h30, 8'h2E, 8'h39, 8'h3B, 8'h35, 8'h30, 8'h2E, 8'h31, 8'h0D, 8'h0A}, "busy", first);
        wait_pronto("busy", first);
        quiet = 1'b1;
        repeat (60) begin
            @(negedge clock);
            if (saida_serial !== 1'b1 || ocupado !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL busy_no_second_frame: got activity=1 expected 0"); end
        check_pronto_count("busy", n0 + 1);
    endtask

    task automatic test_reset_mid_frame();
        int cap, first, n0, st;
        logic [7:0] b;
        bit ok, quiet;
        logic [23:0] exp3;
        n0 = n_pronto;
        exp3 = {8'h34, 8'h32, 8'h2E};
        pulse(16'h2A03, 16'h5808, cap);
        for (int i = 0; i < 3; i++) begin
            recv_char(b, st, ok);
            n_cmp++;
            if (!ok || b !== exp3[8*(2-i) +: 8]) begin
                n_err++;
                $display("FAIL midreset char%0d: got 0x%02h framing_ok=%0d expected 0x%02h", i, b, ok, exp3[8*(2-i) +: 8]);
            end
        end
        wait_start(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL midreset char3_start: got none expected start bit"); end
        repeat (BD / 2 + 5 * BD) @(negedge clock);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (saida_serial !== 1'b1) begin n_err++; $display("FAIL midreset_serial: got %b expected 1", saida_serial); end
        n_cmp++;
        if (ocupado !== 1'b0) begin n_err++; $display("FAIL midreset_ocupado: got %b expected 0", ocupado); end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        quiet = 1'b1;
        repeat (50) begin
            @(negedge clock);
            if (saida_serial !== 1'b1 || ocupado !== 1'b0) quiet = 1'b0;
        end
        n_cmp++;
        if (!quiet) begin n_err++; $display("FAIL midreset_idle: got activity=1 expected 0"); end
        check_pronto_count("midreset_abandoned", n0);
        pulse(16'h6307, 16'h0A00, cap);
        recv_frame({8'h39, 8'h39, 8'h2E, 8'h37, 8'h3B, 8'h31, 8'h30, 8'h2E, 8'h30, 8'h0D, 8'h0A}, "after_reset", first);
        wait_pronto("after_reset", first);
        check_pronto_count("after_reset", n0 + 1);
    endtask

    task automatic test_back_to_back();
        int cap, first, n0;
        n0 = n_pronto;
        pulse(16'h0000, 16'h6209, cap);
        recv_frame({8'h30, 8'h30, 8'h2E, 8'h30, 8'h3B, 8'h39, 8'h38, 8'h2E, 8'h39, 8'h0D, 8'h0A}, "b2b_first", first);
        wait_pronto("b2b_first", first);
        // request coincident with pronto: FSM is in FIM, must be dropped
        temperatura = 16'h5555;
        umidade     = 16'h5555;
        transmitir  = 1'b1;
        @(negedge clock);
        transmitir = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (ocupado !== 1'b0 || saida_serial !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_ignored: got ocupado=%b serial=%b expected 0/1", ocupado, saida_serial);
        end
        pulse(16'h1905, 16'h3C00, cap);
        recv_frame({8'h32, 8'h35, 8'h2E, 8'h35, 8'h3B, 8'h36, 8'h30, 8'h2E, 8'h30, 8'h0D, 8'h0A}, "b2b_second", first);
        wait_pronto("b2b_second", first);
        @(negedge clock);
        temperatura = 16'h6200;
        umidade     = 16'h0109;
        transmitir  = 1'b1;
        @(negedge clock);
        transmitir = 1'b0;
        cap = cyc;
        n_cmp++;
        if (ocupado !== 1'b1) begin n_err++; $display("FAIL b2b_accept: got ocupado=%b expected 1", ocupado); end
        recv_frame({8'h39, 8'h38, 8'h2E, 8'h30, 8'h3B, 8'h30, 8'h31, 8'h2E, 8'h39, 8'h0D, 8'h0A}, "b2b_third", first);
        check_latency("b2b_third", cap, first);
        wait_pronto("b2b_third", first);
        check_pronto_count("b2b", n0 + 3);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_saturation();
        test_busy_rejection();
        test_reset_mid_frame();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
